// File: rtl/frame_sum_accumulator.sv
// Multi-channel frame accumulator: sums NUM_OF_LINES line sums per channel
// and presents one result per frame through a one-deep valid/ready register.
module frame_sum_accumulator #(
   parameter int LINE_SIZE    = 64,
   parameter int PIXEL_SIZE   = 8,
   parameter int NUM_OF_LINES = 8,
   parameter int NUM_CH       = 2,
   localparam int LSW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
   localparam int ASW = $clog2(NUM_OF_LINES) + LSW,
   localparam int CW  = $clog2(NUM_OF_LINES + 1)
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_CH*LSW-1:0] line_sum,
   input  logic                  avg_mode,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NUM_CH*ASW-1:0] frame_sum,
   output logic [CW-1:0]         line_cnt
);

   localparam int          SH   = $clog2(NUM_OF_LINES);
   localparam logic [CW-1:0] LAST = CW'(NUM_OF_LINES - 1);

   logic [CW-1:0]                line_cnt_q, line_cnt_d;
   logic                         mode_q, mode_d;
   logic                         out_valid_q, out_valid_d;
   logic [NUM_CH-1:0][ASW-1:0]   acc_q, acc_d;
   logic [NUM_CH-1:0][ASW-1:0]   frame_q, frame_d;
   logic [NUM_CH-1:0][ASW-1:0]   sum_w;
   logic                         first, last, accept;

   assign first    = (line_cnt_q == '0);
   assign last     = (line_cnt_q == LAST);
   assign in_ready = !(last && out_valid_q && !out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // An empty accumulator (line_cnt==0) is reloaded rather than added to.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         sum_w[c] = {{(ASW-LSW){1'b0}}, line_sum[c*LSW +: LSW]};
         if (!first) begin
            sum_w[c] = acc_q[c] + sum_w[c];
         end
      end
   end

   always_comb begin
      line_cnt_d  = line_cnt_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      acc_d       = acc_q;
      frame_d     = frame_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (flush) begin
         line_cnt_d = '0;
      end else if (accept) begin
         acc_d = sum_w;
         if (first) begin
            mode_d = avg_mode;
         end
         if (last) begin
            for (int c = 0; c < NUM_CH; c++) begin
               frame_d[c] = mode_q ? (sum_w[c] >> SH) : sum_w[c];
            end
            out_valid_d = 1'b1;
            line_cnt_d  = '0;
         end else begin
            line_cnt_d = line_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         line_cnt_q  <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         frame_q     <= '0;
      end else begin
         line_cnt_q  <= line_cnt_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         frame_q     <= frame_d;
      end
   end

   assign out_valid = out_valid_q;
   assign frame_sum = frame_q;
   assign line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_frame_sum_accumulator.sv
// Directed bench for frame_sum_accumulator with default parameters
// (LSW=22, ASW=25, CW=4).
module tb_frame_sum_accumulator;

   localparam int LSW = 22;
   localparam int ASW = 25;
   localparam int CW  = 4;

   logic             CLK = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [2*LSW-1:0] line_sum;
   logic             avg_mode;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [2*ASW-1:0] frame_sum;
   logic [CW-1:0]    line_cnt;
   logic [ASW-1:0]   fs0, fs1;

   int checks = 0;
   int errors = 0;

   assign fs0 = frame_sum[ASW-1:0];
   assign fs1 = frame_sum[2*ASW-1:ASW];

   always #5 CLK = ~CLK;

   frame_sum_accumulator dut (
      .CLK       (CLK),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .line_sum  (line_sum),
      .avg_mode  (avg_mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_sum (frame_sum),
      .line_cnt  (line_cnt)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; in_valid = 1'b0; line_sum = '0;
      avg_mode = 1'b0; flush = 1'b0; out_ready = 1'b1;
      cyc();
      reset = 1'b1;
   endtask

   task automatic send(input logic [LSW-1:0] a, input logic [LSW-1:0] b,
                       input logic m);
      in_valid = 1'b1; line_sum = {b, a}; avg_mode = m;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
      end
      if (frame_sum !== '0) begin
         errors++; $display("FAIL rst_frame_sum got %h want 0", frame_sum);
      end
      if (line_cnt !== '0) begin
         errors++; $display("FAIL rst_line_cnt got %0d want 0", line_cnt);
      end
   endtask

   task automatic test_sum();
      do_reset();
      for (int i = 0; i < 7; i++) send(22'd10, LSW'(i + 1), 1'b0);
      checks += 2;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL sum_early_valid got %b want 0", out_valid);
      end
      if (line_cnt !== 4'd7) begin
         errors++; $display("FAIL sum_cnt7 got %0d want 7", line_cnt);
      end
      send(22'd10, 22'd8, 1'b0);
      checks += 4;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL sum_valid got %b want 1", out_valid);
      end
      if (fs0 !== 25'd80) begin
         errors++; $display("FAIL sum_ch0 got %0d want 80", fs0);
      end
      if (fs1 !== 25'd36) begin
         errors++; $display("FAIL sum_ch1 got %0d want 36", fs1);
      end
      if (line_cnt !== 4'd0) begin
         errors++; $display("FAIL sum_cnt0 got %0d want 0", line_cnt);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL sum_pulse got %b want 0", out_valid);
      end
   endtask

   task automatic test_avg();
      do_reset();
      for (int i = 0; i < 8; i++) send(22'd10, LSW'(i + 1), (i < 3));
      checks += 3;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL avg_valid got %b want 1", out_valid);
      end
      if (fs0 !== 25'd10) begin
         errors++; $display("FAIL avg_ch0 got %0d want 10", fs0);
      end
      if (fs1 !== 25'd4) begin
         errors++; $display("FAIL avg_ch1 got %0d want 4", fs1);
      end
   endtask

   task automatic test_max();
      do_reset();
      for (int i = 0; i < 8; i++) send(22'h3FFFFF, 22'h3FFFFF, 1'b0);
      checks += 2;
      if (fs0 !== 25'd33554424) begin
         errors++; $display("FAIL max_ch0 got %0d want 33554424", fs0);
      end
      if (fs1 !== 25'd33554424) begin
         errors++; $display("FAIL max_ch1 got %0d want 33554424", fs1);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(22'd5, 22'd1, 1'b0);
      for (int i = 0; i < 7; i++) send(22'd7, 22'd2, 1'b0);
      checks += 3;
      if (line_cnt !== 4'd7) begin
         errors++; $display("FAIL bp_cnt got %0d want 7", line_cnt);
      end
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_valid got %b want 1", out_valid);
      end
      if (fs0 !== 25'd40 || fs1 !== 25'd8) begin
         errors++; $display("FAIL bp_hold1 got %0d/%0d want 40/8", fs0, fs1);
      end
      in_valid = 1'b1; line_sum = {22'd2, 22'd7};
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_stall got %b want 0", in_ready);
      end
      @(posedge CLK); #1;
      checks += 2;
      if (line_cnt !== 4'd7) begin
         errors++; $display("FAIL bp_cnt_hold got %0d want 7", line_cnt);
      end
      if (fs0 !== 25'd40 || fs1 !== 25'd8) begin
         errors++; $display("FAIL bp_hold2 got %0d/%0d want 40/8", fs0, fs1);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got %b want 1", in_ready);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      checks += 3;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_no_bubble got %b want 1", out_valid);
      end
      if (fs0 !== 25'd56 || fs1 !== 25'd16) begin
         errors++; $display("FAIL bp_frame2 got %0d/%0d want 56/16", fs0, fs1);
      end
      if (line_cnt !== 4'd0) begin
         errors++; $display("FAIL bp_cnt0 got %0d want 0", line_cnt);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) send(22'd3, 22'd3, 1'b0);
      flush = 1'b1;
      send(22'd100, 22'd100, 1'b0);
      flush = 1'b0;
      checks += 2;
      if (line_cnt !== 4'd0) begin
         errors++; $display("FAIL fl_cnt got %0d want 0", line_cnt);
      end
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL fl_valid got %b want 0", out_valid);
      end
      for (int i = 0; i < 8; i++) send(22'd1, 22'd1, 1'b0);
      checks += 3;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL fl_done got %b want 1", out_valid);
      end
      if (fs0 !== 25'd8 || fs1 !== 25'd8) begin
         errors++; $display("FAIL fl_sum got %0d/%0d want 8/8", fs0, fs1);
      end
      if (line_cnt !== 4'd0) begin
         errors++; $display("FAIL fl_cnt_end got %0d want 0", line_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(22'd2, 22'd2, 1'b0);
      for (int i = 0; i < 3; i++) send(22'd2, 22'd2, 1'b0);
      checks += 2;
      if (out_valid !== 1'b1 || line_cnt !== 4'd3) begin
         errors++;
         $display("FAIL rm_setup got v=%b cnt=%0d want v=1 cnt=3",
                  out_valid, line_cnt);
      end
      if (fs0 !== 25'd16) begin
         errors++; $display("FAIL rm_pending got %0d want 16", fs0);
      end
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      checks += 4;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rm_valid got %b want 0", out_valid);
      end
      if (frame_sum !== '0) begin
         errors++; $display("FAIL rm_frame got %h want 0", frame_sum);
      end
      if (line_cnt !== 4'd0) begin
         errors++; $display("FAIL rm_cnt got %0d want 0", line_cnt);
      end
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rm_in_ready got %b want 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_sum();
      test_avg();
      test_max();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
